// File: rtl/regfile_pkg.sv
// Shared constants and packed-port helpers for the multi-port register file
// and its busy scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // LSB offset of port k inside a packed per-port bus of lane width w.
  function automatic int slice_addr(input int k, input int w = DEF_ADDR_W);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_sb_ctrl.sv
// Busy scoreboard: one busy bit per register plus an incrementally
// maintained count of busy entries. Issue (set) beats writeback (clear).
module regfile_sb_ctrl
  import regfile_pkg::*;
#(
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int ZERO_REG = 1,
  localparam int DEPTH    = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wr_ok, is_ok, inc, dec;

  always_comb begin
    wr_ok  = wen    && !(ZERO_REG != 0 && waddr    == ADDR_W'(ZERO_ADDR));
    is_ok  = iss_en && !(ZERO_REG != 0 && iss_addr == ADDR_W'(ZERO_ADDR));
    busy_d = busy_q;
    if (wr_ok) busy_d[waddr]    = 1'b0;
    if (is_ok) busy_d[iss_addr] = 1'b1;
    // A clear on the same address as a set is swallowed by the set.
    inc    = is_ok && !busy_q[iss_addr];
    dec    = wr_ok && busy_q[waddr] && !(is_ok && iss_addr == waddr);
    cnt_d  = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with optional write-to-read bypass and a
// busy scoreboard for RAW hazard detection between decode and writeback.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int NREAD    = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int DEPTH    = 2**ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [NREAD-1:0]        rbusy,
  output logic                    stall,
  output logic [ADDR_W:0]         busy_cnt
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             busy;
  logic                         wr_ok;

  assign wr_ok = wen && !(ZERO_REG != 0 && waddr == ADDR_W'(ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (rst)        mem_q        <= '0;
    else if (wr_ok) mem_q[waddr] <= wdata;
  end

  regfile_sb_ctrl #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    localparam int ALO = slice_addr(k, ADDR_W);
    localparam int DLO = slice_addr(k, DATA_W);
    logic [ADDR_W-1:0] ra;
    logic              zhit, byp;
    assign ra   = raddr[ALO +: ADDR_W];
    assign zhit = ZERO_REG != 0 && ra == ADDR_W'(ZERO_ADDR);
    assign byp  = BYPASS != 0 && wen && waddr == ra;
    assign rdata[DLO +: DATA_W] = zhit ? '0 : byp ? wdata : mem_q[ra];
    // A producer retiring this cycle is forwarded, so it no longer stalls.
    assign rbusy[k] = busy[ra] && !byp && !zhit;
  end

  assign stall = |rbusy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized and directed checking of two configurations of regfile_mp_sb
// against array-based reference models of the register file and scoreboard.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wen, iss_en;
  // Config A: 32x32, 2 read ports, bypass, hardwired zero
  logic [4:0]  waddrA, issA;
  logic [31:0] wdataA;
  logic [9:0]  raddrA;
  logic [63:0] rdataA;
  logic [1:0]  rbusyA;
  logic        stallA;
  logic [5:0]  cntA;
  // Config B: 8x16, 4 read ports, no bypass, entry 0 is ordinary
  logic [2:0]  waddrB, issB;
  logic [15:0] wdataB;
  logic [11:0] raddrB;
  logic [63:0] rdataB;
  logic [3:0]  rbusyB;
  logic        stallB;
  logic [3:0]  cntB;

  regfile_mp_sb dutA (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddrA), .wdata(wdataA),
    .raddr(raddrA), .rdata(rdataA), .iss_en(iss_en), .iss_addr(issA),
    .rbusy(rbusyA), .stall(stallA), .busy_cnt(cntA)
  );

  regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .BYPASS(0), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddrB), .wdata(wdataB),
    .raddr(raddrB), .rdata(rdataB), .iss_en(iss_en), .iss_addr(issB),
    .rbusy(rbusyB), .stall(stallB), .busy_cnt(cntB[3:0])
  );

  logic [31:0] memA [32];
  bit          busyA[32];
  logic [15:0] memB [8];
  bit          busyB[8];
  int n_cmp = 0, n_err = 0;
  bit started = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk)
    if (started) assert (cntA <= 6'd32 && cntB <= 4'd8) else $error("busy_cnt out of range");

  // Combinational outputs against the model's pre-edge state.
  task automatic pre();
    logic [31:0] eA; logic [15:0] eB; bit bA, bB, sA, sB; int a;
    #1;
    sA = 0; sB = 0;
    for (int k = 0; k < 2; k++) begin
      a = int'(raddrA[k*5 +: 5]);
      if (a == 0) begin eA = 0; bA = 0; end
      else if (wen && int'(waddrA) == a) begin eA = wdataA; bA = 0; end
      else begin eA = memA[a]; bA = busyA[a]; end
      sA |= bA;
      chk($sformatf("rdA%0d", k), 64'(rdataA[k*32 +: 32]), 64'(eA));
      chk($sformatf("rbusyA%0d", k), 64'(rbusyA[k]), 64'(bA));
    end
    chk("stallA", 64'(stallA), 64'(sA));
    for (int k = 0; k < 4; k++) begin
      a = int'(raddrB[k*3 +: 3]);
      eB = memB[a]; bB = busyB[a];
      sB |= bB;
      chk($sformatf("rdB%0d", k), 64'(rdataB[k*16 +: 16]), 64'(eB));
      chk($sformatf("rbusyB%0d", k), 64'(rbusyB[k]), 64'(bB));
    end
    chk("stallB", 64'(stallB), 64'(sB));
  endtask

  // Clock edge, model update, registered count check, back to negedge.
  task automatic edge_();
    int cA, cB;
    @(posedge clk);
    if (rst) begin
      foreach (memA[i]) begin memA[i] = 0; busyA[i] = 0; end
      foreach (memB[i]) begin memB[i] = 0; busyB[i] = 0; end
    end else begin
      if (wen && waddrA != 0) begin memA[waddrA] = wdataA; busyA[waddrA] = 0; end
      if (iss_en && issA != 0) busyA[issA] = 1;
      if (wen) begin memB[waddrB] = wdataB; busyB[waddrB] = 0; end
      if (iss_en) busyB[issB] = 1;
    end
    #1;
    cA = 0; cB = 0;
    foreach (busyA[i]) cA += int'(busyA[i]);
    foreach (busyB[i]) cB += int'(busyB[i]);
    chk("cntA", 64'(cntA), 64'(cA));
    chk("cntB", 64'(cntB), 64'(cB));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wen = 0; iss_en = 0;
  endtask

  initial begin
    foreach (memA[i]) begin memA[i] = 0; busyA[i] = 0; end
    foreach (memB[i]) begin memB[i] = 0; busyB[i] = 0; end
    rst = 1; wen = 0; iss_en = 0;
    waddrA = 0; issA = 0; wdataA = 0; raddrA = {5'd3, 5'd0};
    waddrB = 0; issB = 0; wdataB = 0; raddrB = {3'd3, 3'd2, 3'd1, 3'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    started = 1;
    pre();
    chk("rst_rdA", rdataA, 64'h0);
    chk("rst_stall", 64'(stallA | stallB), 64'h0);
    chk("rst_cnt", 64'({cntA, cntB}), 64'h0);
    edge_();

    // Same-cycle write and read of entry 7
    idle(); wen = 1; waddrA = 7; wdataA = 32'hDEADBEEF; raddrA = {5'd3, 5'd7};
    waddrB = 7; wdataB = 16'hBEEF; raddrB = {3'd1, 3'd2, 3'd3, 3'd7};
    pre();
    chk("byp_A", 64'(rdataA[31:0]), 64'hDEADBEEF);
    chk("nobyp_B", 64'(rdataB[15:0]), 64'h0);
    edge_();
    idle(); pre();
    chk("nobyp_B_next", 64'(rdataB[15:0]), 64'hBEEF);
    edge_();

    // Writes and issues to entry 0
    idle(); wen = 1; waddrA = 0; wdataA = 32'hFFFFFFFF; iss_en = 1; issA = 0;
    raddrA = {5'd0, 5'd0}; waddrB = 0; wdataB = 16'h00AA; issB = 0;
    pre(); chk("zero_rd", 64'(rdataA[31:0]), 64'h0);
    edge_();
    idle(); pre();
    chk("zero_rd2", 64'(rdataA[31:0]), 64'h0);
    chk("zero_rbusy", 64'(rbusyA), 64'h0);
    chk("zero_cnt", 64'(cntA), 64'h0);
    edge_();

    // RAW hazard on entry 9
    idle(); iss_en = 1; issA = 9; issB = 1;
    pre(); edge_();
    idle(); raddrA = {5'd9, 5'd0}; raddrB = {3'd0, 3'd0, 3'd1, 3'd0};
    pre();
    chk("haz_cnt", 64'(cntA), 64'h1);
    chk("haz_rbusy", 64'(rbusyA[1]), 64'h1);
    chk("haz_stall", 64'(stallA), 64'h1);
    edge_();
    idle(); wen = 1; waddrA = 9; wdataA = 32'd5; waddrB = 1; wdataB = 16'd5;
    pre();
    chk("haz_fwd_rbusy", 64'(rbusyA[1]), 64'h0);
    chk("haz_nobyp_B", 64'(rbusyB[1]), 64'h1);
    edge_();
    idle(); pre();
    chk("haz_clr_cnt", 64'(cntA), 64'h0);
    chk("haz_rd", 64'(rdataA[63:32]), 64'd5);
    edge_();

    // Set and clear of entry 12 in the same cycle
    idle(); iss_en = 1; issA = 12; issB = 4;
    pre(); edge_();
    wen = 1; waddrA = 12; wdataA = 32'h1234; waddrB = 4; wdataB = 16'h1234;
    pre(); edge_();
    idle(); raddrA = {5'd0, 5'd12}; raddrB = {3'd4, 3'd4, 3'd4, 3'd4};
    pre();
    chk("sc_cnt", 64'(cntA), 64'h1);
    chk("sc_rbusy", 64'(rbusyA[0]), 64'h1);
    chk("sc_rd", 64'(rdataA[31:0]), 64'h1234);
    edge_();
    idle(); wen = 1; waddrA = 12; waddrB = 4;
    pre(); edge_();

    // Reset in the middle of in-flight producers
    for (int i = 1; i <= 3; i++) begin
      idle(); iss_en = 1; issA = 5'(i); issB = 3'(i);
      pre(); edge_();
    end
    idle(); pre();
    chk("mid_cnt3", 64'(cntA), 64'h3);
    rst = 1; wen = 1; waddrA = 1; wdataA = 32'h77; waddrB = 1; wdataB = 16'h77;
    edge_();
    idle(); raddrA = {5'd1, 5'd1}; raddrB = {3'd1, 3'd2, 3'd3, 3'd1};
    pre();
    chk("mid_cnt", 64'(cntA), 64'h0);
    chk("mid_cntB", 64'(cntB), 64'h0);
    chk("mid_rd", 64'(rdataA[31:0]), 64'h0);
    chk("mid_stall", 64'(stallA | stallB), 64'h0);
    edge_();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      wen    = ($urandom_range(0, 1) == 1);
      iss_en = ($urandom_range(0, 9) < 4);
      waddrA = 5'($urandom); issA = 5'($urandom); wdataA = $urandom;
      raddrA = 10'($urandom);
      if ($urandom_range(0, 3) == 0) raddrA[4:0] = waddrA;
      waddrB = 3'($urandom); issB = 3'($urandom); wdataB = 16'($urandom);
      raddrB = 12'($urandom);
      pre(); edge_();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
